// File: rtl/dpram_stream_reader.sv
// Read-side sweep engine for the dual-port RAM: walks a run of addresses,
// hides the one-cycle registered read latency and emits bytes on a valid/ready stream.
module dpram_stream_reader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  length,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] ram_q,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, OUT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  remaining;
  logic              last_byte;

  assign last_byte = (remaining == LEN_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      rd_addr   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (length != '0) begin
              cur_addr  <= start_addr;
              remaining <= length;
              // rd_addr is loaded on entry to ISSUE so the RAM samples it at the
              // end of ISSUE and ram_q is already valid during CAPTURE.
              rd_addr   <= start_addr;
              busy      <= 1'b1;
              state     <= ISSUE;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ISSUE: begin
          rd_addr <= cur_addr;
          state   <= CAPTURE;
        end
        CAPTURE: begin
          out_data  <= ram_q;
          out_valid <= 1'b1;
          out_last  <= last_byte;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            remaining <= remaining - 1'b1;
            cur_addr  <= cur_addr + 1'b1;
            rd_addr   <= cur_addr + 1'b1;
            if (last_byte) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              state <= ISSUE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Randomized self-checking bench: a registered-read RAM model plus a queue-based
// expectation of which bytes appear, at which handshake edge, and when done fires.
module tb_dpram_stream_reader;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 5;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [LEN_W-1:0]  length = '0;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              out_last;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] mem [DEPTH];
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  logic [DATA_W-1:0] hs_data[$];
  logic              hs_last[$];
  logic [ADDR_W-1:0] hs_addr[$];
  int                hs_edge[$];
  int                hs_stall[$];

  dpram_stream_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .length(length),
    .rd_addr(rd_addr), .ram_q(ram_q), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) ram_q <= mem[rd_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ram_default();
    for (int k = 0; k < DEPTH; k++) mem[k] = 8'hA0 + 8'(k);
  endtask

  // mode 0: ready always high, 1: random ready, 2: first valid byte stalled 5 cycles
  task automatic do_run(input string nm, input int sa, input int len, input int mode, input bit poke);
    int e0, stall, held, done_at;
    bit got;
    logic pv, pl, pr;
    logic [DATA_W-1:0] pd;
    hs_data.delete(); hs_last.delete(); hs_addr.delete(); hs_edge.delete(); hs_stall.delete();
    stall = 0; held = 0; got = 0; done_at = 0;
    out_ready = (mode != 2);
    start = 1'b1; start_addr = ADDR_W'(sa); length = LEN_W'(len);
    e0 = cyc + 1;
    tick();
    start = 1'b0; start_addr = ADDR_W'($urandom); length = LEN_W'($urandom);
    compared++;
    if (busy !== (len != 0)) begin
      mismatched++; $display("FAIL %s busy_after_accept got %b want %b", nm, busy, (len != 0));
    end
    for (int k = 0; k < 600; k++) begin
      if (done) begin got = 1; done_at = cyc; break; end
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(1));
        default: begin
          if (out_valid && held < 5) begin out_ready = 1'b0; held++; end
          else out_ready = 1'b1;
        end
      endcase
      if (poke && k == 4) begin
        start = 1'b1; start_addr = ADDR_W'(sa + 7); length = 5'd31;
      end else start = 1'b0;
      if (out_valid && !out_ready) stall++;
      if (out_valid && out_ready) begin
        hs_data.push_back(out_data); hs_last.push_back(out_last);
        hs_addr.push_back(rd_addr); hs_edge.push_back(cyc + 1); hs_stall.push_back(stall);
      end
      pv = out_valid; pd = out_data; pl = out_last; pr = out_ready;
      tick();
      if (pv && !pr) begin
        compared++;
        if (out_valid !== 1'b1 || out_data !== pd || out_last !== pl) begin
          mismatched++;
          $display("FAIL %s hold got v=%b d=%h l=%b want v=1 d=%h l=%b", nm, out_valid, out_data, out_last, pd, pl);
        end
      end
    end
    start = 1'b0;
    compared++;
    if (!got) begin
      mismatched++; $display("FAIL %s done_timeout got none want done pulse", nm);
      return;
    end
    if (done_at != e0 + 3 * len + stall) begin
      mismatched++; $display("FAIL %s done_cycle got %0d want %0d", nm, done_at, e0 + 3 * len + stall);
    end
    compared++;
    if (busy !== 1'b0) begin
      mismatched++; $display("FAIL %s busy_at_done got %b want 0", nm, busy);
    end
    compared++;
    if (hs_data.size() != len) begin
      mismatched++; $display("FAIL %s byte_count got %0d want %0d", nm, hs_data.size(), len);
    end
    for (int i = 0; i < hs_data.size() && i < len; i++) begin
      compared++;
      if (hs_data[i] !== mem[(sa + i) % DEPTH] || hs_last[i] !== (i == len - 1) ||
          hs_addr[i] !== ADDR_W'((sa + i) % DEPTH) || hs_edge[i] != e0 + 3 * (i + 1) + hs_stall[i]) begin
        mismatched++;
        $display("FAIL %s byte%0d got d=%h l=%b a=%h e=%0d want d=%h l=%b a=%h e=%0d", nm, i,
                 hs_data[i], hs_last[i], hs_addr[i], hs_edge[i], mem[(sa + i) % DEPTH],
                 (i == len - 1), ADDR_W'((sa + i) % DEPTH), e0 + 3 * (i + 1) + hs_stall[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; out_ready = 1'b1; length = 5'd3; start_addr = 4'd2;
    for (int k = 0; k < 3; k++) begin
      tick();
      compared++;
      if ({rd_addr, out_data, out_valid, out_last, busy, done} !== '0) begin
        mismatched++;
        $display("FAIL reset_outputs got a=%h d=%h v=%b l=%b b=%b dn=%b want all 0",
                 rd_addr, out_data, out_valid, out_last, busy, done);
      end
    end
    start = 1'b0;
    rst_n = 1'b1;
    tick(); tick();
    compared++;
    if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
      mismatched++; $display("FAIL reset_release got b=%b dn=%b v=%b want 0 0 0", busy, done, out_valid);
    end
  endtask

  task automatic test_basic();         do_run("basic", 2, 3, 0, 0);   endtask
  task automatic test_wrap();          do_run("wrap", 14, 4, 0, 0);   endtask
  task automatic test_backpressure();  do_run("backpressure", 2, 2, 2, 0); endtask
  task automatic test_zero_length();   do_run("zero_len", 7, 0, 0, 0); endtask
  task automatic test_busy_start();    do_run("busy_start", 1, 5, 0, 1); endtask

  task automatic test_back_to_back();
    do_run("b2b_first", 9, 2, 0, 0);
    do_run("b2b_second", 15, 3, 1, 0);
    do_run("b2b_full_wrap", 3, 31, 0, 0);
  endtask

  task automatic test_reset_midrun();
    int k;
    out_ready = 1'b0;
    start = 1'b1; start_addr = 4'd3; length = 5'd4;
    tick();
    start = 1'b0;
    for (k = 0; k < 10 && !out_valid; k++) tick();
    compared++;
    if (!out_valid) begin
      mismatched++; $display("FAIL midrun_reach_out got v=%b want 1", out_valid);
    end
    tick(); tick();
    rst_n = 1'b0;
    #1;
    compared++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0 || done !== 1'b0 || rd_addr !== '0) begin
      mismatched++;
      $display("FAIL midrun_reset got v=%b b=%b l=%b dn=%b a=%h want 0 0 0 0 0", out_valid, busy, out_last, done, rd_addr);
    end
    tick();
    rst_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      compared++;
      if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
        mismatched++; $display("FAIL midrun_after got dn=%b b=%b v=%b want 0 0 0", done, busy, out_valid);
      end
    end
    do_run("after_reset", 5, 1, 0, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < DEPTH; k++) mem[k] = 8'($urandom);
    for (int r = 0; r < 8; r++)
      do_run("random", int'($urandom_range(DEPTH - 1)), int'($urandom_range(31, 1)), 1, bit'(r == 3));
    load_ram_default();
  endtask

  initial begin
    load_ram_default();
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_length();
    test_busy_start();
    test_back_to_back();
    test_reset_midrun();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
